// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle for instruction_fetch_unit.
// master = fetch unit side, slave = memory/execute/decode side.
interface instruction_fetch_unit_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] Inst_Addr;
    logic [31:0]     Instruction;
    logic            Branch_Taken;
    logic [XLEN-1:0] Branch_Target;
    logic            Out_Ready;
    logic            Out_Valid;
    logic [31:0]     Out_Instruction;
    logic [XLEN-1:0] Out_PC;
    logic            Fetch_Fault;

    modport master (
        output Inst_Addr, Out_Valid, Out_Instruction, Out_PC, Fetch_Fault,
        input  Instruction, Branch_Taken, Branch_Target, Out_Ready
    );

    modport slave (
        input  Inst_Addr, Out_Valid, Out_Instruction, Out_PC, Fetch_Fault,
        output Instruction, Branch_Taken, Branch_Target, Out_Ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RISC-V fetch stage: owns the PC and fills a registered IF/ID slot with valid/ready handshake.
// Defining FETCH_PERF_EN adds saturating Fetch_Count / Flush_Count outputs.
module instruction_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INSN = 32'h00000013
) (
    input logic                      clk,
    input logic                      reset_n,
    instruction_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              Fetch_Count,
    output logic [31:0]              Flush_Count
`endif
);
    typedef enum logic [1:0] {BOOT, FETCH, FAULT} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_insn;
    logic            out_valid;
    logic            fault;
    logic            slot_free;
    logic            misaligned;
`ifdef FETCH_PERF_EN
    logic [31:0]     fetch_count;
    logic [31:0]     flush_count;
`endif

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign slot_free  = !out_valid || bus.Out_Ready;
    assign misaligned = bus.Branch_Target[1:0] != 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_insn  <= NOP_INSN;
            out_pc    <= '0;
            fault     <= 1'b0;
`ifdef FETCH_PERF_EN
            fetch_count <= '0;
            flush_count <= '0;
`endif
        end else begin
            case (state)
                BOOT: state <= FETCH;
                FETCH: begin
                    if (bus.Branch_Taken && misaligned) begin
                        state     <= FAULT;
                        fault     <= 1'b1;
                        out_valid <= 1'b0;
                        out_insn  <= NOP_INSN;
                    end else if (bus.Branch_Taken) begin
                        // Redirect flushes the slot even when decode is stalling it.
                        pc        <= bus.Branch_Target;
                        out_valid <= 1'b0;
                        out_insn  <= NOP_INSN;
`ifdef FETCH_PERF_EN
                        if (out_valid) flush_count <= sat_inc(flush_count);
`endif
                    end else if (slot_free) begin
                        out_insn  <= bus.Instruction;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + XLEN'(4);
`ifdef FETCH_PERF_EN
                        fetch_count <= sat_inc(fetch_count);
`endif
                    end
                end
                FAULT: begin
                    out_valid <= 1'b0;
                    out_insn  <= NOP_INSN;
                    fault     <= 1'b1;
                end
                default: state <= FAULT;
            endcase
        end
    end

    assign bus.Inst_Addr       = pc;
    assign bus.Out_Valid       = out_valid;
    assign bus.Out_Instruction = out_insn;
    assign bus.Out_PC          = out_pc;
    assign bus.Fetch_Fault     = fault;
`ifdef FETCH_PERF_EN
    assign Fetch_Count = fetch_count;
    assign Flush_Count = flush_count;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit with a small combinational memory model.
// Counter checks are active when FETCH_PERF_EN is defined.
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    instruction_fetch_unit_if #(.XLEN(64)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
    instruction_fetch_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus),
                                .Fetch_Count(fetch_count), .Flush_Count(flush_count));
`else
    instruction_fetch_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'd0:   return 32'h02853483;
            64'd4:   return 32'h009A84B3;
            64'd8:   return 32'h00148493;
            64'd12:  return 32'h02953423;
            default: return {16'hA5A5, a[15:0]};
        endcase
    endfunction

    assign bus.Instruction = mem_word(bus.Inst_Addr);

    typedef struct {
        logic        rdy;
        logic        br;
        logic [63:0] tgt;
        logic        ev;
        logic [31:0] ei;
        logic [63:0] ep;
        logic [63:0] ea;
        int          fc;
        int          flc;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic rdy, input logic br, input logic [63:0] tgt,
                        input logic ev, input logic [31:0] ei, input logic [63:0] ep,
                        input logic [63:0] ea, input int fc, input int flc);
        vec_t v;
        v.rdy = rdy; v.br = br; v.tgt = tgt; v.ev = ev; v.ei = ei;
        v.ep = ep; v.ea = ea; v.fc = fc; v.flc = flc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input string nm, input int fc, input int flc);
`ifdef FETCH_PERF_EN
        chk({nm, ".fetch_count"}, 64'(fetch_count), 64'(fc));
        chk({nm, ".flush_count"}, 64'(flush_count), 64'(flc));
`else
        if (fc < 0 || flc < 0) $display("negative count in %s", nm);
`endif
    endtask

    initial begin
        bus.Branch_Taken  = 1'b0;
        bus.Branch_Target = '0;
        bus.Out_Ready     = 1'b1;

        //         rdy br  tgt                     ev  insn          pc     addr                    fc flc
        addv(1, 0, 64'd0,                 0, NOP,          64'd0, 64'd0,                  0, 0); // BOOT
        addv(1, 0, 64'd0,                 1, 32'h02853483, 64'd0, 64'd4,                  1, 0);
        addv(1, 0, 64'd0,                 1, 32'h009A84B3, 64'd4, 64'd8,                  2, 0);
        addv(1, 0, 64'd0,                 1, 32'h00148493, 64'd8, 64'd12,                 3, 0);
        addv(1, 0, 64'd0,                 1, 32'h02953423, 64'd12, 64'd16,                4, 0);
        addv(1, 1, 64'd0,                 0, NOP,          64'd0, 64'd0,                  4, 1); // redirect + transfer
        addv(1, 0, 64'd0,                 1, 32'h02853483, 64'd0, 64'd4,                  5, 1);
        addv(1, 0, 64'd0,                 1, 32'h009A84B3, 64'd4, 64'd8,                  6, 1);
        addv(0, 0, 64'd0,                 1, 32'h009A84B3, 64'd4, 64'd8,                  6, 1); // stall x3
        addv(0, 0, 64'd0,                 1, 32'h009A84B3, 64'd4, 64'd8,                  6, 1);
        addv(0, 0, 64'd0,                 1, 32'h009A84B3, 64'd4, 64'd8,                  6, 1);
        addv(1, 0, 64'd0,                 1, 32'h00148493, 64'd8, 64'd12,                 7, 1);
        addv(0, 1, 64'd0,                 0, NOP,          64'd0, 64'd0,                  7, 2); // flush stalled slot
        addv(1, 0, 64'd0,                 1, 32'h02853483, 64'd0, 64'd4,                  8, 2);
        addv(1, 1, 64'hFFFFFFFFFFFFFFFC,  0, NOP,          64'd0, 64'hFFFFFFFFFFFFFFFC,   8, 3);
        addv(1, 0, 64'd0,                 1, 32'hA5A5FFFC, 64'hFFFFFFFFFFFFFFFC, 64'd0,   9, 3); // wrap
        addv(1, 0, 64'd0,                 1, 32'h02853483, 64'd0, 64'd4,                 10, 3);

        #1 reset_n = 1'b0;
        step();
        step();
        chk("reset.valid", 64'(bus.Out_Valid), 64'd0);
        chk("reset.insn", 64'(bus.Out_Instruction), 64'(NOP));
        chk("reset.pc", bus.Out_PC, 64'd0);
        chk("reset.fault", 64'(bus.Fetch_Fault), 64'd0);
        chk("reset.addr", bus.Inst_Addr, 64'd0);
        chk_counts("reset", 0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.Out_Ready     = vecs[i].rdy;
            bus.Branch_Taken  = vecs[i].br;
            bus.Branch_Target = vecs[i].tgt;
            step();
            chk($sformatf("v%0d.valid", i), 64'(bus.Out_Valid), 64'(vecs[i].ev));
            chk($sformatf("v%0d.insn", i), 64'(bus.Out_Instruction), 64'(vecs[i].ei));
            if (vecs[i].ev) chk($sformatf("v%0d.pc", i), bus.Out_PC, vecs[i].ep);
            chk($sformatf("v%0d.addr", i), bus.Inst_Addr, vecs[i].ea);
            chk($sformatf("v%0d.fault", i), 64'(bus.Fetch_Fault), 64'd0);
            chk_counts($sformatf("v%0d", i), vecs[i].fc, vecs[i].flc);
        end

        // Misaligned redirect: fault is sticky and ignores further redirects.
        bus.Out_Ready     = 1'b1;
        bus.Branch_Taken  = 1'b1;
        bus.Branch_Target = 64'h6;
        step();
        chk("fault.entry.fault", 64'(bus.Fetch_Fault), 64'd1);
        chk("fault.entry.valid", 64'(bus.Out_Valid), 64'd0);
        chk("fault.entry.insn", 64'(bus.Out_Instruction), 64'(NOP));
        chk("fault.entry.addr", bus.Inst_Addr, 64'd4);
        for (int i = 0; i < 10; i++) begin
            bus.Branch_Taken  = i[0];
            bus.Branch_Target = 64'h100;
            step();
            chk($sformatf("fault.hold%0d.fault", i), 64'(bus.Fetch_Fault), 64'd1);
            chk($sformatf("fault.hold%0d.valid", i), 64'(bus.Out_Valid), 64'd0);
            chk($sformatf("fault.hold%0d.addr", i), bus.Inst_Addr, 64'd4);
        end
        bus.Branch_Taken = 1'b0;

        #3 reset_n = 1'b0;
        #1;
        chk("fault.rst.fault", 64'(bus.Fetch_Fault), 64'd0);
        chk("fault.rst.valid", 64'(bus.Out_Valid), 64'd0);
        chk("fault.rst.addr", bus.Inst_Addr, 64'd0);
        chk_counts("fault.rst", 0, 0);
        #1 reset_n = 1'b1;
        step();
        chk("restart.boot.valid", 64'(bus.Out_Valid), 64'd0);
        step();
        chk("restart.first.valid", 64'(bus.Out_Valid), 64'd1);
        chk("restart.first.insn", 64'(bus.Out_Instruction), 64'h02853483);
        chk("restart.first.pc", bus.Out_PC, 64'd0);
        step();
        chk("restart.second.insn", 64'(bus.Out_Instruction), 64'h009A84B3);
        chk("restart.second.valid", 64'(bus.Out_Valid), 64'd1);

        // Asynchronous reset mid-cycle with a valid slot: must clear before the next edge.
        #3 reset_n = 1'b0;
        #1;
        chk("async.valid", 64'(bus.Out_Valid), 64'd0);
        chk("async.insn", 64'(bus.Out_Instruction), 64'(NOP));
        chk("async.pc", bus.Out_PC, 64'd0);
        chk("async.addr", bus.Inst_Addr, 64'd0);
        #1 reset_n = 1'b1;
        step();
        chk("async.boot.valid", 64'(bus.Out_Valid), 64'd0);
        step();
        chk("async.first.valid", 64'(bus.Out_Valid), 64'd1);
        chk("async.first.insn", 64'(bus.Out_Instruction), 64'h02853483);
        chk("async.first.addr", bus.Inst_Addr, 64'd4);
        chk_counts("async.first", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the RISC-V core. Owns the program counter (PC) and drives Inst_Addr into the combinational instruction memory.
- Captures the returned Instruction, together with its PC, into a registered IF/ID output slot with a valid/ready handshake toward decode.
- Handles branch/jump redirects with a flush of the output slot, and traps misaligned redirect targets.

Parameters:
- XLEN, 64, width of PC and address paths
- RESET_PC, 64'h0, PC value loaded on reset
- NOP_INSN, 32'h00000013, value driven on Out_Instruction when the slot is empty or reset

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- Inst_Addr  out  XLEN  byte address to instruction memory; equals PC combinationally
- Instruction  in  32  instruction word returned by memory in the same cycle
- Branch_Taken  in  1  redirect request from execute
- Branch_Target  in  XLEN  redirect PC, sampled when Branch_Taken=1
- Out_Ready  in  1  decode can accept the slot contents this cycle
- Out_Valid  out  1  slot holds a valid fetched instruction
- Out_Instruction  out  32  fetched instruction
- Out_PC  out  XLEN  PC of Out_Instruction
- Fetch_Fault  out  1  sticky misaligned-target fault

Behaviour:
- Reset, asynchronous: asserting reset_n=0 immediately forces:
  - PC=RESET_PC, state=BOOT
  - Out_Valid=0, Out_Instruction=NOP_INSN, Out_PC=0, Fetch_Fault=0
  - The same applies mid-operation; any in-flight slot is discarded.
- State machine:
  - BOOT: one cycle after reset release. No capture, Out_Valid stays 0, then go to FETCH. Branch_Taken is ignored in BOOT.
  - FETCH: normal operation (rules below).
  - FAULT: PC frozen, Out_Valid=0, Fetch_Fault=1. Exit only by reset.
- Slot free condition: slot_free = !Out_Valid || Out_Ready.
- FETCH priority, highest first, evaluated each rising edge:
  1. Branch_Taken=1 with Branch_Target[1:0]!=0: go to FAULT, Out_Valid<=0, PC unchanged.
  2. Branch_Taken=1 with an aligned target:
     - PC<=Branch_Target, Out_Valid<=0 (flush). The flush applies even if the slot was stalled.
     - The instruction currently at Inst_Addr is not captured.
  3. slot_free=1:
     - Out_Instruction<=Instruction, Out_PC<=PC, Out_Valid<=1
     - PC<=PC+4, wrapping modulo 2^XLEN (no carry out).
  4. Otherwise (stall): PC, Out_Instruction, Out_PC and Out_Valid all hold.
- Latency and throughput:
  - The first valid instruction appears on the 2nd rising edge after reset release (the edge that ends BOOT is the 1st).
  - Throughput is 1 instruction/cycle while Out_Ready=1.
- Redirect penalty: exactly 1 bubble. The instruction at Branch_Target becomes valid one edge after the redirect edge.
- Handshake rules:
  - A transfer occurs on an edge where Out_Valid=1 and Out_Ready=1.
  - Out_* must not change while Out_Valid=1 and Out_Ready=0, except when flushed by a redirect.
- Empty slot: whenever Out_Valid=0, Out_Instruction=NOP_INSN.
- Simultaneous events: Out_Ready=1 and Branch_Taken=1 in the same cycle means the current slot transfers, then is replaced by a bubble. Decode consumes the old slot on that edge.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs Fetch_Count [31:0] and Flush_Count [31:0], both reset to 0 asynchronously.
  - Fetch_Count increments on every capture (priority 3).
  - Flush_Count increments on every aligned redirect that discards Out_Valid=1.
  - Both counters saturate at 32'hFFFFFFFF.
- Not defined: the ports and counters are absent, and there is no other behavioural difference.

Test Plan:
- Memory model: words 0x02853483 @0, 0x009A84B3 @4, 0x00148493 @8, 0x02953423 @12.
- Reset release, Out_Ready=1 held -> Out_Valid=0 for the BOOT cycle. Then Out_Instruction/Out_PC sequence is 0x02853483/0, 0x009A84B3/4, 0x00148493/8, 0x02953423/12 on consecutive edges.
- Out_Ready=0 for 3 cycles while slot holds 0x009A84B3/4 -> outputs stable and Inst_Addr stays 8. The first edge with Out_Ready=1 presents 0x00148493/8.
- Branch_Taken=1, Branch_Target=0 while slot holds PC 8 and Out_Ready=0 -> next edge gives Out_Valid=0 and Out_Instruction=0x00000013. The following edge gives 0x02853483/0.
- Branch_Taken=1, Branch_Target=0x6 -> Fetch_Fault=1 and Out_Valid=0 persist for 10+ cycles. reset_n pulse low clears both and restarts at PC 0.
- PC preloaded via redirect to 0xFFFFFFFFFFFFFFFC -> after capture, Inst_Addr=0 (wrap).
- reset_n asserted asynchronously mid-cycle with Out_Valid=1 -> Out_Valid falls to 0 before the next clock edge.
- With FETCH_PERF_EN: 4 captures, 1 flush of a valid slot -> Fetch_Count=4, Flush_Count=1.
